// File: rtl/regfile_pkg.sv
// Shared register-file defines used by decode and the register file.
package regfile_pkg;
  localparam int REG_NUM = 32;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t ZERO_REG = '0;
endpackage

// File: rtl/regfile_if.sv
// Decode/write-back side bundle of the register file.
interface regfile_if #(
  parameter int DATA_W = regfile_pkg::DATA_W
);
  logic                readEnable1_i;
  regfile_pkg::addr_t  readAddr1_i;
  logic [DATA_W-1:0]   readData1_o;
  logic                readEnable2_i;
  regfile_pkg::addr_t  readAddr2_i;
  logic [DATA_W-1:0]   readData2_o;
  logic                writeEnable_i;
  regfile_pkg::addr_t  writeAddr_i;
  logic [DATA_W-1:0]   writeData_i;
  logic                reserveEnable_i;
  regfile_pkg::addr_t  reserveAddr_i;
  logic                stall_o;

  modport master (
    output readEnable1_i, readAddr1_i,
    output readEnable2_i, readAddr2_i,
    output writeEnable_i, writeAddr_i,
    output writeData_i,
    output reserveEnable_i, reserveAddr_i,
    input  readData1_o, readData2_o,
    input  stall_o
  );

  modport slave (
    input  readEnable1_i, readAddr1_i,
    input  readEnable2_i, readAddr2_i,
    input  writeEnable_i, writeAddr_i,
    input  writeData_i,
    input  reserveEnable_i, reserveAddr_i,
    output readData1_o, readData2_o,
    output stall_o
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters and the decode stall.
module reg_scoreboard #(
  parameter int REG_NUM = regfile_pkg::REG_NUM
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en1_i,
  input  regfile_pkg::addr_t rd_addr1_i,
  input  logic               rd_en2_i,
  input  regfile_pkg::addr_t rd_addr2_i,
  input  logic               wr_en_i,
  input  regfile_pkg::addr_t wr_addr_i,
  input  logic               rsv_en_i,
  input  regfile_pkg::addr_t rsv_addr_i,
  output logic               stall_o
);
  import regfile_pkg::*;

  logic [1:0] cnt_q [REG_NUM];
  logic [1:0] cnt_d [REG_NUM];

  logic [1:0] cnt1, cnt2, cntr;
  logic       hit1, hit2, hitr;
  logic       hz1, hz2, ovf, stall;

  always_comb begin
    cnt1 = '0;
    cnt2 = '0;
    cntr = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (rd_addr1_i == ADDR_W'(i)) cnt1 = cnt_q[i];
      if (rd_addr2_i == ADDR_W'(i)) cnt2 = cnt_q[i];
      if (rsv_addr_i == ADDR_W'(i)) cntr = cnt_q[i];
    end
    hit1 = wr_en_i && (wr_addr_i == rd_addr1_i);
    hit2 = wr_en_i && (wr_addr_i == rd_addr2_i);
    hitr = wr_en_i && (wr_addr_i == rsv_addr_i);
    // A single outstanding write retiring this cycle is bypassed
    hz1 = rd_en1_i && (rd_addr1_i != ZERO_REG) &&
          ((cnt1 > 2'd1) || ((cnt1 == 2'd1) && !hit1));
    hz2 = rd_en2_i && (rd_addr2_i != ZERO_REG) &&
          ((cnt2 > 2'd1) || ((cnt2 == 2'd1) && !hit2));
    ovf = rsv_en_i && (rsv_addr_i != ZERO_REG) &&
          (cntr == 2'd3) && !hitr;
    stall = !rst && (hz1 || hz2 || ovf);
  end

  assign stall_o = stall;

  always_comb begin
    logic inc;
    logic dec;
    for (int i = 0; i < REG_NUM; i++) begin
      inc = rsv_en_i && (rsv_addr_i == ADDR_W'(i)) && !stall;
      dec = wr_en_i && (wr_addr_i == ADDR_W'(i)) &&
            (cnt_q[i] != 2'd0);
      cnt_d[i] = cnt_q[i];
      if (inc && !dec)      cnt_d[i] = cnt_q[i] + 2'd1;
      else if (dec && !inc) cnt_d[i] = cnt_q[i] - 2'd1;
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '{default: '0};
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/regfile.sv
// Architectural register file with write-back bypass and hazard stall.
module regfile #(
  parameter int REG_NUM = regfile_pkg::REG_NUM,
  parameter int DATA_W  = regfile_pkg::DATA_W
) (
  input logic     clk,
  input logic     rst,
  regfile_if.slave bus
);
  import regfile_pkg::*;

  logic [DATA_W-1:0] mem_q [REG_NUM];
  logic [DATA_W-1:0] mem_d [REG_NUM];
  logic [DATA_W-1:0] st1, st2, rd1, rd2;
  logic              wr_ok;

  assign wr_ok = bus.writeEnable_i && (bus.writeAddr_i != ZERO_REG);

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < REG_NUM; i++) begin
      if (wr_ok && (bus.writeAddr_i == ADDR_W'(i)))
        mem_d[i] = bus.writeData_i;
    end
    mem_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) mem_q <= '{default: '0};
    else     mem_q <= mem_d;
  end

  always_comb begin
    st1 = '0;
    st2 = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (bus.readAddr1_i == ADDR_W'(i)) st1 = mem_q[i];
      if (bus.readAddr2_i == ADDR_W'(i)) st2 = mem_q[i];
    end
    rd1 = '0;
    rd2 = '0;
    if (!rst && bus.readEnable1_i && (bus.readAddr1_i != ZERO_REG))
      rd1 = (wr_ok && (bus.writeAddr_i == bus.readAddr1_i)) ?
            bus.writeData_i : st1;
    if (!rst && bus.readEnable2_i && (bus.readAddr2_i != ZERO_REG))
      rd2 = (wr_ok && (bus.writeAddr_i == bus.readAddr2_i)) ?
            bus.writeData_i : st2;
  end

  assign bus.readData1_o = rd1;
  assign bus.readData2_o = rd2;

  reg_scoreboard #(
    .REG_NUM (REG_NUM)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .rd_en1_i   (bus.readEnable1_i),
    .rd_addr1_i (bus.readAddr1_i),
    .rd_en2_i   (bus.readEnable2_i),
    .rd_addr2_i (bus.readAddr2_i),
    .wr_en_i    (bus.writeEnable_i),
    .wr_addr_i  (bus.writeAddr_i),
    .rsv_en_i   (bus.reserveEnable_i),
    .rsv_addr_i (bus.reserveAddr_i),
    .stall_o    (bus.stall_o)
  );
endmodule

// File: tb/tb_regfile.sv
// Directed scenarios plus random traffic against a reference model.
module tb_regfile;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  regfile_if bus ();

  regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_mem [32];
  int          m_cnt [32];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic en,
                                         input logic [4:0] a);
    if (rst || !en || a == 5'd0) return 32'd0;
    if (bus.writeEnable_i && bus.writeAddr_i == a)
      return bus.writeData_i;
    return m_mem[a];
  endfunction

  function automatic logic hz(input logic en, input logic [4:0] a);
    logic hit;
    hit = bus.writeEnable_i && bus.writeAddr_i == a;
    if (!en || a == 5'd0) return 1'b0;
    return m_cnt[a] > 1 || (m_cnt[a] == 1 && !hit);
  endfunction

  function automatic logic exp_stall();
    logic ovf;
    if (rst) return 1'b0;
    ovf = bus.reserveEnable_i && bus.reserveAddr_i != 5'd0 &&
          m_cnt[bus.reserveAddr_i] == 3 &&
          !(bus.writeEnable_i &&
            bus.writeAddr_i == bus.reserveAddr_i);
    return ovf ||
           hz(bus.readEnable1_i, bus.readAddr1_i) ||
           hz(bus.readEnable2_i, bus.readAddr2_i);
  endfunction

  // Reference model advances on the same edge as the DUT
  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        m_mem[r] = 32'd0;
        m_cnt[r] = 0;
      end
    end else begin
      logic st;
      st = exp_stall();
      for (int r = 1; r < 32; r++) begin
        int d;
        d = 0;
        if (bus.reserveEnable_i && bus.reserveAddr_i == 5'(r) && !st)
          d = d + 1;
        if (bus.writeEnable_i && bus.writeAddr_i == 5'(r) &&
            m_cnt[r] > 0)
          d = d - 1;
        m_cnt[r] = m_cnt[r] + d;
      end
      if (bus.writeEnable_i && bus.writeAddr_i != 5'd0)
        m_mem[bus.writeAddr_i] = bus.writeData_i;
    end
  end

  always @(negedge clk) begin
    chk("rd1", bus.readData1_o,
        exp_rd(bus.readEnable1_i, bus.readAddr1_i));
    chk("rd2", bus.readData2_o,
        exp_rd(bus.readEnable2_i, bus.readAddr2_i));
    chk("stall", {31'd0, bus.stall_o}, {31'd0, exp_stall()});
  end

  task automatic set_in(input logic e1, input logic [4:0] a1,
                        input logic e2, input logic [4:0] a2,
                        input logic we, input logic [4:0] wa,
                        input logic [31:0] wd,
                        input logic re, input logic [4:0] ra);
    bus.readEnable1_i   = e1;
    bus.readAddr1_i     = a1;
    bus.readEnable2_i   = e2;
    bus.readAddr2_i     = a2;
    bus.writeEnable_i   = we;
    bus.writeAddr_i     = wa;
    bus.writeData_i     = wd;
    bus.reserveEnable_i = re;
    bus.reserveAddr_i   = ra;
  endtask

  task automatic at_mid();
    @(negedge clk);
    #1;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    for (int r = 0; r < 32; r++) begin
      m_mem[r] = 32'd0;
      m_cnt[r] = 0;
    end
    set_in(1, 5, 1, 5, 0, 0, 0, 0, 0);
    rst = 1'b1;
    next();
    at_mid();
    chk("rst_rd1", bus.readData1_o, 32'd0);
    chk("rst_stall", {31'd0, bus.stall_o}, 32'd0);
    next();
    rst = 1'b0;

    set_in(0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
    next();
    set_in(1, 5, 0, 0, 0, 0, 0, 0, 0);
    at_mid();
    chk("r5_read", bus.readData1_o, 32'hDEADBEEF);
    next();
    set_in(0, 5, 0, 0, 0, 0, 0, 0, 0);
    at_mid();
    chk("r5_noen", bus.readData1_o, 32'd0);
    next();

    set_in(1, 0, 1, 0, 1, 0, 32'h1234, 0, 0);
    at_mid();
    chk("r0_byp1", bus.readData1_o, 32'd0);
    chk("r0_byp2", bus.readData2_o, 32'd0);
    next();
    set_in(1, 0, 1, 0, 0, 0, 0, 0, 0);
    at_mid();
    chk("r0_rd1", bus.readData1_o, 32'd0);
    chk("r0_rd2", bus.readData2_o, 32'd0);
    next();

    set_in(0, 0, 1, 7, 1, 7, 32'hA5A5A5A5, 0, 0);
    at_mid();
    chk("r7_byp", bus.readData2_o, 32'hA5A5A5A5);
    next();

    set_in(0, 0, 0, 0, 0, 0, 0, 1, 3);
    at_mid();
    chk("r3_rsv", {31'd0, bus.stall_o}, 32'd0);
    next();
    set_in(1, 3, 0, 0, 0, 0, 0, 0, 0);
    at_mid();
    chk("r3_haz", {31'd0, bus.stall_o}, 32'd1);
    next();
    set_in(1, 3, 0, 0, 1, 3, 32'd9, 0, 0);
    at_mid();
    chk("r3_wb_stall", {31'd0, bus.stall_o}, 32'd0);
    chk("r3_wb_data", bus.readData1_o, 32'd9);
    next();

    for (int k = 0; k < 3; k++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 4);
      at_mid();
      chk("r4_rsv", {31'd0, bus.stall_o}, 32'd0);
      next();
    end
    at_mid();
    chk("r4_ovf", {31'd0, bus.stall_o}, 32'd1);
    next();
    at_mid();
    chk("r4_held", {31'd0, bus.stall_o}, 32'd1);
    next();
    set_in(0, 0, 0, 0, 1, 4, 32'h44, 1, 4);
    at_mid();
    chk("r4_rsv_wb", {31'd0, bus.stall_o}, 32'd0);
    next();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 4);
    at_mid();
    chk("r4_same", {31'd0, bus.stall_o}, 32'd1);
    next();

    set_in(0, 0, 0, 0, 1, 2, 32'h55, 0, 0);
    next();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 2);
    next();
    next();
    set_in(1, 2, 0, 0, 0, 0, 0, 0, 0);
    at_mid();
    chk("r2_haz", {31'd0, bus.stall_o}, 32'd1);
    chk("r2_data", bus.readData1_o, 32'h55);
    next();
    rst = 1'b1;
    at_mid();
    chk("r2_inrst_d", bus.readData1_o, 32'd0);
    chk("r2_inrst_s", {31'd0, bus.stall_o}, 32'd0);
    next();
    rst = 1'b0;
    at_mid();
    chk("r2_post_d", bus.readData1_o, 32'd0);
    chk("r2_post_s", {31'd0, bus.stall_o}, 32'd0);
    next();

    for (int c = 0; c < 3000; c++) begin
      set_in($urandom_range(0, 3) != 0, rnd_addr(),
             $urandom_range(0, 3) != 0, rnd_addr(),
             $urandom_range(0, 1) == 1, rnd_addr(), $urandom(),
             $urandom_range(0, 2) == 0, rnd_addr());
      rst = ($urandom_range(0, 199) == 0);
      next();
    end
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    next();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 SHALL have parameter REG_NUM, default 32: number of architectural registers.
REQ-002 SHALL have parameter DATA_W, default 32: register width in bits.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have ports readEnable1_i / readEnable2_i, input, 1: read port 1/2 request from decode.
REQ-006 SHALL have ports readAddr1_i / readAddr2_i, input, 5: read port 1/2 register index.
REQ-007 SHALL have ports readData1_o / readData2_o, output, DATA_W: read port 1/2 data, combinational.
REQ-008 SHALL have port writeEnable_i, input, 1: write-back request.
REQ-009 SHALL have port writeAddr_i, input, 5: write-back register index.
REQ-010 SHALL have port writeData_i, input, DATA_W: write-back data.
REQ-011 SHALL have port reserveEnable_i, input, 1: decode issues an instruction that will write reserveAddr_i.
REQ-012 SHALL have port reserveAddr_i, input, 5: destination of the issuing instruction.
REQ-013 SHALL have port stall_o, output, 1: decode must hold; the operands or the reservation are not yet safe.

Function
REQ-014 Storage SHALL be REG_NUM x DATA_W; register 0 reads as 0, and writes to it are discarded.
REQ-015 Read port n SHALL return 0 when readEnable_n is low or addr == 0.
REQ-016 Read SHALL bypass: if writeEnable_i, writeAddr_i == readAddr_n and addr != 0, return writeData_i the same cycle; otherwise return the stored value.
REQ-017 Write SHALL commit at the rising edge when writeEnable_i is high and writeAddr_i != 0; zero latency to the stored value visible next cycle.
REQ-018 The block SHALL keep a 2-bit pending counter per register; entry 0 is always 0.
REQ-019 A counter SHALL increment at the edge when reserveEnable_i is high, reserveAddr_i != 0 and stall_o is low.
REQ-020 A counter SHALL decrement at the edge when writeEnable_i is high, writeAddr_i matches and the counter is > 0.
REQ-021 When increment and decrement hit the same register in the same cycle, the counter SHALL be unchanged.
REQ-022 A write to a register with counter 0 SHALL still commit; the counter stays 0 (no underflow).
REQ-023 Read hazard on port n SHALL be: readEnable_n, addr != 0, and either counter > 1, or counter == 1 with no same-cycle matching write.
REQ-024 Reservation overflow SHALL be: reserveEnable_i, reserveAddr_i != 0, counter[reserveAddr_i] == 3, and no same-cycle matching write.
REQ-025 stall_o SHALL be the OR of both read hazards and the overflow; it is purely combinational with no registered delay.
REQ-026 While stall_o is high, no counter SHALL increment; decrements still apply.

Reset
REQ-027 When rst is high at an edge, all registers SHALL become 0 and all counters 0; writes and reservations in that cycle are ignored.
REQ-028 While rst is high, readData1_o, readData2_o and stall_o SHALL be 0.
REQ-029 Reset mid-operation SHALL discard all outstanding reservations; no state is retained.

Structure
REQ-030 The shared defines package SHALL hold REG_NUM, DATA_W, the address width (5) and the ZERO_REG constant (0), used by decode and by this block.
REQ-031 The pending counters and the stall logic SHALL live in one sub-module, reg_scoreboard; storage and bypass stay in regfile.

Verification
REQ-032 Scenario: write r5 = 0xDEADBEEF; next cycle read port 1 addr 5, enable 1 -> 0xDEADBEEF; enable 0 -> 0.
REQ-033 Scenario: write r0 = 0x1234; read addr 0 on both ports -> 0, including the same-cycle bypass case.
REQ-034 Scenario: write r7 = 0xA5A5A5A5 while port 2 reads r7 in the same cycle -> readData2_o = 0xA5A5A5A5 that cycle.
REQ-035 Scenario: reserve r3; next cycle read r3 -> stall_o = 1; write-back r3 = 9 in the same cycle as the read -> stall_o = 0 and data = 9.
REQ-036 Scenario: reserve r4 three times -> counter = 3; fourth reserve -> stall_o = 1, counter stays 3; reserve plus matching write in one cycle -> counter unchanged, stall_o = 0.
REQ-037 Scenario: with r2 = 0x55 and r2 counter = 2, assert rst for 1 cycle -> r2 reads 0, counters 0, stall_o = 0 on the next read of r2.
